// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the read-side FIFO stream consumer: data width default,
// occupancy encodings and the RAM read latency that sizes the skid buffer.
package fifo_rd_stream_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int READ_LAT       = 1;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   // Projected occupancy after this cycle: held entries plus the arriving word minus the one leaving.
   function automatic logic [2:0] next_load(input logic [1:0] occ, input logic inflight, input logic deq);
      return {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
   endfunction

endpackage

// File: rtl/fifo_rd_stream_skid2.sv
// Two-entry head/tail skid buffer with an EMPTY/ONE/TWO occupancy FSM;
// only the head entry is ever presented downstream.
module stream_skid2
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [1:0]            occ
);

   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] tail;
   logic                  deq;

   assign valid = (occ != OCC_EMPTY);
   assign data  = head;
   assign deq   = valid && ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         occ  <= OCC_EMPTY;
         head <= '0;
         tail <= '0;
      end else begin
         case (occ)
            OCC_EMPTY: begin
               if (push) begin
                  head <= push_data;
                  occ  <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (push && deq) begin
                  head <= push_data;
               end else if (push) begin
                  tail <= push_data;
                  occ  <= OCC_TWO;
               end else if (deq) begin
                  occ <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               // A simultaneous arrival here means a pop slipped through; keep it rather than drop it.
               if (deq) begin
                  head <= tail;
                  if (push) begin
                     tail <= push_data;
                  end else begin
                     occ <= OCC_ONE;
                  end
               end
            end
            default: occ <= OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(occ == OCC_TWO && push && !deq));
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer: issues pops, absorbs the 1-cycle RAM read latency
// and streams words out through a 2-entry skid buffer, counting deliveries.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic                  busy
);

   localparam int BUF_DEPTH = READ_LAT + 1;

   logic       inflight;
   logic       deq;
   logic [1:0] occ;
   logic [2:0] load;

   assign deq  = m_valid && m_ready;
   assign load = next_load(occ, inflight, deq);

   // Only pop when the word returning next cycle is guaranteed a free slot.
   assign fifo_pop = !rst && !fifo_empty && (load < 3'(BUF_DEPTH));
   assign busy     = (occ != OCC_EMPTY) || inflight;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
         word_cnt <= '0;
      end else begin
         inflight <= fifo_pop;
         if (deq) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
         end
      end
   end

   stream_skid2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (fifo_rdata),
      .ready     (m_ready),
      .valid     (m_valid),
      .data      (m_data),
      .occ       (occ)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a small FIFO read-port model feeds the DUT
// and each scenario task checks timing, ordering and the delivered-word counter.
module tb_fifo_rd_stream;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [DW-1:0] fifo_rdata = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [CW-1:0] word_cnt;
   logic          busy;

   logic [DW-1:0] mem [0:63];
   int            wr_count = 0;
   int            rd_ptr   = 0;
   int            pops     = 0;
   int            bad_pops = 0;
   logic [DW-1:0] rx [$];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   fifo_rd_stream #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .fifo_rdata (fifo_rdata),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .word_cnt   (word_cnt),
      .busy       (busy)
   );

   assign fifo_empty = (rd_ptr >= wr_count);

   // FIFO read port with one cycle of RAM latency, plus a handshake monitor.
   always @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= 0;
         pops     <= 0;
         bad_pops <= 0;
         rx.delete();
      end else begin
         if (fifo_pop) begin
            if (fifo_empty) begin
               bad_pops <= bad_pops + 1;
            end else begin
               fifo_rdata <= mem[rd_ptr];
               rd_ptr     <= rd_ptr + 1;
               pops       <= pops + 1;
            end
         end
         if (m_valid && m_ready) rx.push_back(m_data);
      end
   end

   task automatic load(input logic [DW-1:0] w);
      mem[wr_count] = w;
      wr_count++;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      m_ready  = 1'b0;
      wr_count = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      m_ready  = 1'b1;
      wr_count = 0;
      load(32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++; if (fifo_pop !== 1'b0) $display("[TB] FAIL reset_pop[%0d]: got %b expected 0", i, fifo_pop); else passed++;
         checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_valid[%0d]: got %b expected 0", i, m_valid); else passed++;
         checks++; if (m_data !== '0) $display("[TB] FAIL reset_data[%0d]: got %h expected 0", i, m_data); else passed++;
         checks++; if (word_cnt !== '0) $display("[TB] FAIL reset_cnt[%0d]: got %0d expected 0", i, word_cnt); else passed++;
         checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", i, busy); else passed++;
      end
      wr_count = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [4:0]    pv, vv, bv;
      logic [DW-1:0] d2;
      logic [CW-1:0] c3;
      do_reset();
      load(32'hA5A5_0001);
      m_ready = 1'b1;
      rst     = 1'b0;
      d2 = '0;
      c3 = '0;
      for (int i = 0; i < 5; i++) begin
         #1;
         pv[i] = fifo_pop;
         vv[i] = m_valid;
         bv[i] = busy;
         if (i == 2) d2 = m_data;
         if (i == 3) c3 = word_cnt;
         @(negedge clk);
      end
      checks++; if (pv !== 5'b00001) $display("[TB] FAIL single_pop: got %b expected 00001", pv); else passed++;
      checks++; if (vv !== 5'b00100) $display("[TB] FAIL single_valid: got %b expected 00100", vv); else passed++;
      checks++; if (bv !== 5'b00110) $display("[TB] FAIL single_busy: got %b expected 00110", bv); else passed++;
      checks++; if (d2 !== 32'hA5A5_0001) $display("[TB] FAIL single_data: got %h expected a5a50001", d2); else passed++;
      checks++; if (c3 !== 4'd1) $display("[TB] FAIL single_cnt: got %0d expected 1", c3); else passed++;
   endtask

   task automatic test_stream();
      logic [13:0] vv;
      int          bad;
      do_reset();
      for (int k = 0; k < 8; k++) load(32'h10 + k);
      m_ready = 1'b1;
      rst     = 1'b0;
      for (int i = 0; i < 14; i++) begin
         #1;
         vv[i] = m_valid;
         @(negedge clk);
      end
      bad = 0;
      for (int k = 0; k < rx.size(); k++) if (rx[k] !== 32'h10 + k) bad++;
      checks++; if (vv !== 14'h03FC) $display("[TB] FAIL stream_valid: got %b expected 00001111111100", vv); else passed++;
      checks++; if (rx.size() != 8 || bad != 0) $display("[TB] FAIL stream_order: got %0d words (%0d wrong) expected 8 in order", rx.size(), bad); else passed++;
      checks++; if (word_cnt !== 4'd8) $display("[TB] FAIL stream_cnt: got %0d expected 8", word_cnt); else passed++;
   endtask

   task automatic test_backpressure();
      logic stable;
      int   n, bad;
      do_reset();
      for (int k = 0; k < 8; k++) load(32'h10 + k);
      m_ready = 1'b1;
      rst     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 32'h10) $display("[TB] FAIL bp_first: got valid=%b data=%h expected 1/00000010", m_valid, m_data); else passed++;
      m_ready = 1'b0;
      stable  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (m_valid !== 1'b1 || m_data !== 32'h10) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) $display("[TB] FAIL bp_hold: got unstable head expected 00000010 held"); else passed++;
      checks++; if (pops != 2) $display("[TB] FAIL bp_pops: got %0d expected 2", pops); else passed++;
      checks++; if (fifo_pop !== 1'b0) $display("[TB] FAIL bp_pop_blocked: got %b expected 0", fifo_pop); else passed++;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL bp_busy: got %b expected 1", busy); else passed++;
      m_ready = 1'b1;
      n = 0;
      while (rx.size() < 8 && n < 30) begin
         @(negedge clk);
         n++;
      end
      bad = 0;
      for (int k = 0; k < rx.size(); k++) if (rx[k] !== 32'h10 + k) bad++;
      checks++; if (rx.size() != 8 || bad != 0) $display("[TB] FAIL bp_order: got %0d words (%0d wrong) expected 8 in order", rx.size(), bad); else passed++;
      checks++; if (word_cnt !== 4'd8) $display("[TB] FAIL bp_cnt: got %0d expected 8", word_cnt); else passed++;
   endtask

   task automatic test_bubble();
      logic [9:0] vv, pv;
      do_reset();
      load(32'h20);
      load(32'h21);
      m_ready = 1'b1;
      rst     = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) load(32'h22);
         #1;
         vv[i] = m_valid;
         pv[i] = fifo_pop;
         @(negedge clk);
      end
      checks++; if (vv !== 10'h08C) $display("[TB] FAIL bubble_valid: got %b expected 0010001100", vv); else passed++;
      checks++; if (pv !== 10'h023) $display("[TB] FAIL bubble_pop: got %b expected 0000100011", pv); else passed++;
      checks++; if (bad_pops != 0) $display("[TB] FAIL bubble_empty_pop: got %0d expected 0", bad_pops); else passed++;
      checks++; if (rx.size() != 3 || rx[0] !== 32'h20 || rx[1] !== 32'h21 || rx[2] !== 32'h22)
         $display("[TB] FAIL bubble_order: got %0d words expected 20,21,22", rx.size()); else passed++;
      checks++; if (word_cnt !== 4'd3) $display("[TB] FAIL bubble_cnt: got %0d expected 3", word_cnt); else passed++;
   endtask

   task automatic test_wrap_and_reset();
      int n;
      do_reset();
      for (int k = 0; k < 17; k++) load(32'h100 + k);
      m_ready = 1'b1;
      rst     = 1'b0;
      n = 0;
      while (rx.size() < 17 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++; if (rx.size() != 17) $display("[TB] FAIL wrap_timeout: got %0d words expected 17", rx.size()); else passed++;
      checks++; if (word_cnt !== 4'd1) $display("[TB] FAIL wrap_cnt: got %0d expected 1", word_cnt); else passed++;
      checks++; if (rx.size() == 0 || rx[rx.size()-1] !== 32'h110) $display("[TB] FAIL wrap_last: got %0d words expected last 00000110", rx.size()); else passed++;
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) load(32'h200 + k);
      repeat (4) @(negedge clk);
      #1;
      checks++; if (m_valid !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL full_pre: got valid=%b busy=%b expected 1/1", m_valid, busy); else passed++;
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (m_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %b expected 0", m_valid); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
      checks++; if (word_cnt !== 4'd0) $display("[TB] FAIL rst_mid_cnt: got %0d expected 0", word_cnt); else passed++;
      checks++; if (fifo_pop !== 1'b0) $display("[TB] FAIL rst_mid_pop: got %b expected 0", fifo_pop); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_bubble();
      test_wrap_and_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the dual-clock FIFO controller. It lives in the read clock domain.
- Issues pops to the FIFO read port (r_valid/empty/r_data) and absorbs the fixed 1-cycle RAM read latency.
- Presents the data downstream as a valid/ready stream with a 2-entry skid buffer. This gives full throughput with zero loss under backpressure.
- Counts delivered words for status.

Parameters:
- DATA_WIDTH, 32, width of FIFO read data and stream data.
- CNT_WIDTH, 16, width of delivered-word counter.
- BUF_DEPTH, 2, skid entries; fixed at 2 (read latency 1 plus 1), not user-tunable.

Ports:
- clk  in  1  read-domain clock (same clock as the FIFO read side)
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag (read domain)
- fifo_pop  out  1  pop request to FIFO r_valid; combinational from registered state and fifo_empty
- fifo_rdata  in  DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted pop
- m_valid  out  1  stream data valid
- m_data  out  DATA_WIDTH  stream data (head entry)
- m_ready  in  1  downstream accept
- word_cnt  out  CNT_WIDTH  count of completed m_valid&&m_ready handshakes, wraps modulo 2^CNT_WIDTH
- busy  out  1  high when any entry is held or a read is in flight

Behaviour:
- Reset is synchronous, active-high: rst sampled high at posedge clk clears everything. Reset values:
  - m_valid=0, m_data=0, word_cnt=0, busy=0.
  - occupancy=0, inflight=0.
  - fifo_pop=0 while rst is high (gated).
- Pop and capture timing:
  - Accepted pop: fifo_pop=1 at edge N (the FIFO advances only if !fifo_empty).
  - inflight=1 for cycle N+1.
  - fifo_rdata is written into the tail entry at edge N+1.
- Downstream handshake:
  - deq = m_valid && m_ready.
  - Only the head entry is ever presented.
  - m_data is stable while m_valid && !m_ready.
- Pop rule:
  - fifo_pop = !rst && !fifo_empty && (occ + inflight - deq) < 2.
  - occ is 0..2 and registered; inflight is 0..1 and registered.
  - This guarantees the buffer never overflows, so an arriving word always has a free slot.
- Occupancy FSM: states EMPTY(0), ONE(1), TWO(2); next occ = occ + inflight - deq.
  - EMPTY, inflight arrives: go to ONE, head<=fifo_rdata, m_valid=1 next cycle.
  - ONE, arrival and deq: stay ONE, head<=fifo_rdata.
  - ONE, arrival, no deq: go to TWO, tail<=fifo_rdata.
  - ONE, deq, no arrival: go to EMPTY.
  - TWO, deq: head<=tail, go to ONE. Arrival in TWO cannot happen by construction; flag it as an assertion.
  - TWO, deq plus arrival cannot happen (pop was blocked the prior cycle unless deq was predicted). If it does: head<=tail, tail<=fifo_rdata, stay TWO.
- Latency and throughput:
  - Latency from FIFO non-empty to m_valid is 2 cycles: pop edge, capture edge, m_valid visible.
  - Sustained throughput is 1 word/cycle when m_ready is held high and the FIFO is non-empty.
- FIFO empty mid-stream: fifo_pop=0 and nothing is lost. Held entries drain normally; m_valid drops after the last entry dequeues.
- Counter and status:
  - word_cnt increments by 1 on each deq; 2^CNT_WIDTH-1 wraps to 0 with no flag.
  - busy = (occ != 0) || inflight.
- Reset mid-operation:
  - Buffered and in-flight words are discarded; m_valid deasserts at the reset edge.
  - The system must reset the FIFO controller in the same window. No realignment logic exists in this block.

Decomposition:
- Shared package/defines: DATA_WIDTH default (tie to the existing data-width define), occupancy state encodings EMPTY/ONE/TWO, READ_LAT=1 constant.
- One sub-module is natural: stream_skid2 (2-entry head/tail buffer with occupancy FSM). The top holds the pop logic, inflight flag, counter and busy.

Test Plan:
- Reset checks: hold rst 3 cycles with fifo_empty=0 -> fifo_pop=0, m_valid=0, m_data=0, word_cnt=0, busy=0 throughout.
- Single word: FIFO holds 0xA5A5_0001, m_ready=1 -> fifo_pop high 1 cycle, m_valid at cycle +2 with m_data=0xA5A5_0001, word_cnt=1, busy returns 0.
- Streaming: 8 words 0x10..0x17, m_ready=1 -> after 2-cycle fill, m_valid continuous 8 cycles, data in order, word_cnt=8.
- Backpressure: 8 words, m_ready low for 5 cycles after the first word -> pops stop with occ=2, m_data holds 0x10 stable, no loss. Release -> 0x10..0x17 in order.
- Empty bubble: FIFO provides 0x20, 0x21, then empty 3 cycles, then 0x22, m_ready=1 -> m_valid gap of 3 cycles, order preserved, no pop issued while fifo_empty=1.
- Counter wrap and reset: CNT_WIDTH=4, 17 words -> word_cnt=1. Assert rst with occ=2 -> m_valid=0 and busy=0 on the next edge.
